// File: rtl/rd_txn_guard.sv
// Passive AXI read-channel watchdog: tracks outstanding AR transactions, checks
// per-phase latency budgets and ID ordering, and raises sticky error flags.
module rd_txn_guard #(
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned MaxTxns  = 8,
  parameter int unsigned CntWidth = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                guard_ena_i,
  input  logic                ar_valid_i,
  input  logic                ar_ready_i,
  input  logic [IdWidth-1:0]  ar_id_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic [IdWidth-1:0]  r_id_i,
  input  logic [CntWidth-1:0] budget_arvld_arrdy_i,
  input  logic [CntWidth-1:0] budget_arrdy_rfirst_i,
  input  logic [CntWidth-1:0] budget_rfirst_rlast_i,
  input  logic                clear_i,
  output logic [4:0]          err_o,
  output logic [IdWidth-1:0]  fault_id_o,
  output logic                full_o,
  output logic                irq_o,
  output logic                rst_req_o
);

  localparam int unsigned OrdWidth = $clog2(MaxTxns);

  typedef enum logic {
    WAIT_FIRST,
    WAIT_LAST
  } phase_t;

  logic [MaxTxns-1:0]  valid_q, valid_d;
  logic [IdWidth-1:0]  id_q    [MaxTxns];
  logic [IdWidth-1:0]  id_d    [MaxTxns];
  phase_t              phase_q [MaxTxns];
  phase_t              phase_d [MaxTxns];
  logic [CntWidth-1:0] cnt_q   [MaxTxns];
  logic [CntWidth-1:0] cnt_d   [MaxTxns];
  logic [OrdWidth-1:0] ord_q   [MaxTxns];
  logic [OrdWidth-1:0] ord_d   [MaxTxns];

  logic [CntWidth-1:0] stall_q, stall_d, stall_inc;
  logic [4:0]          err_q, err_d, new_err;
  logic [IdWidth-1:0]  fault_q, fault_d, fault_sel;
  logic                rst_req_q, rst_req_d;

  logic                ar_hs, r_beat, match_hit, alloc_hit, freeing;
  logic [MaxTxns-1:0]  match_oh, alloc_oh;
  logic [OrdWidth-1:0] same_cnt;
  logic                rf_hit, rl_hit;
  logic [IdWidth-1:0]  rf_id, rl_id;

  // Lookup works on registered state only, so a slot freed this cycle is not
  // yet visible as free and a newly allocated slot cannot be matched.
  always_comb begin : lookup
    ar_hs     = ar_valid_i & ar_ready_i & guard_ena_i;
    r_beat    = r_valid_i & r_ready_i & guard_ena_i;
    match_hit = 1'b0;
    match_oh  = '0;
    alloc_hit = 1'b0;
    alloc_oh  = '0;
    for (int unsigned i = 0; i < MaxTxns; i++) begin
      if (!match_hit && valid_q[i] && id_q[i] == r_id_i && ord_q[i] == '0) begin
        match_hit   = 1'b1;
        match_oh[i] = 1'b1;
      end
      if (!alloc_hit && !valid_q[i]) begin
        alloc_hit   = 1'b1;
        alloc_oh[i] = 1'b1;
      end
    end
    freeing  = r_beat & match_hit & r_last_i;
    same_cnt = '0;
    for (int unsigned i = 0; i < MaxTxns; i++) begin
      if (valid_q[i] && id_q[i] == ar_id_i && !(freeing && match_oh[i])) begin
        same_cnt = same_cnt + 1'b1;
      end
    end
  end

  always_comb begin : entry_update
    valid_d = valid_q;
    id_d    = id_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    rf_hit  = 1'b0;
    rl_hit  = 1'b0;
    rf_id   = '0;
    rl_id   = '0;
    if (guard_ena_i) begin
      for (int unsigned i = 0; i < MaxTxns; i++) begin
        if (valid_q[i]) begin
          if (phase_q[i] == WAIT_FIRST && budget_arrdy_rfirst_i != '0 &&
              cnt_q[i] == budget_arrdy_rfirst_i && !rf_hit) begin
            rf_hit = 1'b1;
            rf_id  = id_q[i];
          end
          if (phase_q[i] == WAIT_LAST && budget_rfirst_rlast_i != '0 &&
              cnt_q[i] == budget_rfirst_rlast_i && !rl_hit) begin
            rl_hit = 1'b1;
            rl_id  = id_q[i];
          end
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
          if (r_beat && match_oh[i]) begin
            if (r_last_i) begin
              valid_d[i] = 1'b0;
            end else if (phase_q[i] == WAIT_FIRST) begin
              phase_d[i] = WAIT_LAST;
              cnt_d[i]   = '0;
            end
          end else if (freeing && id_q[i] == r_id_i && ord_q[i] != '0) begin
            ord_d[i] = ord_q[i] - 1'b1;
          end
        end else if (ar_hs && alloc_oh[i]) begin
          valid_d[i] = 1'b1;
          id_d[i]    = ar_id_i;
          phase_d[i] = WAIT_FIRST;
          cnt_d[i]   = '0;
          ord_d[i]   = same_cnt;
        end
      end
    end
  end

  always_comb begin : err_next
    stall_d   = stall_q;
    new_err   = '0;
    stall_inc = (stall_q == '1) ? stall_q : stall_q + 1'b1;
    if (guard_ena_i) begin
      if (!ar_valid_i || ar_ready_i) begin
        stall_d = '0;
      end else begin
        stall_d    = stall_inc;
        new_err[0] = (budget_arvld_arrdy_i != '0) && (stall_inc == budget_arvld_arrdy_i);
      end
      new_err[1] = rf_hit;
      new_err[2] = rl_hit;
      new_err[3] = ar_hs & ~alloc_hit;
      new_err[4] = r_beat & ~match_hit;
    end
    if (new_err[0])      fault_sel = ar_id_i;
    else if (new_err[1]) fault_sel = rf_id;
    else if (new_err[2]) fault_sel = rl_id;
    else if (new_err[3]) fault_sel = ar_id_i;
    else                 fault_sel = r_id_i;
    if (clear_i) begin
      err_d     = '0;
      fault_d   = '0;
      rst_req_d = 1'b0;
    end else begin
      err_d     = err_q | new_err;
      fault_d   = (err_q == '0 && new_err != '0) ? fault_sel : fault_q;
      rst_req_d = rst_req_q | (|new_err[2:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < MaxTxns; i++) begin
        id_q[i]    <= '0;
        phase_q[i] <= WAIT_FIRST;
        cnt_q[i]   <= '0;
        ord_q[i]   <= '0;
      end
      stall_q   <= '0;
      err_q     <= '0;
      fault_q   <= '0;
      rst_req_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      id_q      <= id_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ord_q     <= ord_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
      fault_q   <= fault_d;
      rst_req_q <= rst_req_d;
    end
  end

  assign err_o      = err_q;
  assign fault_id_o = fault_q;
  assign irq_o      = |err_q;
  assign rst_req_o  = rst_req_q;
  assign full_o     = &valid_q;

endmodule

// File: tb/tb_rd_txn_guard.sv
// Self-checking bench for rd_txn_guard: directed scenarios plus randomized
// traffic compared each cycle against an age-ordered transaction model.
module tb_rd_txn_guard;

  localparam int unsigned IW = 4;
  localparam int unsigned NT = 8;
  localparam int unsigned CW = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          ar_valid = 1'b0, ar_ready = 1'b0;
  logic [IW-1:0] ar_id = '0;
  logic          r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
  logic [IW-1:0] r_id = '0;
  logic [CW-1:0] b_ar = '0, b_rf = '0, b_rl = '0;
  logic          clear = 1'b0;
  logic [4:0]    err;
  logic [IW-1:0] fault_id;
  logic          full, irq, rst_req;

  rd_txn_guard #(.IdWidth(IW), .MaxTxns(NT), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .guard_ena_i(ena),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last), .r_id_i(r_id),
    .budget_arvld_arrdy_i(b_ar), .budget_arrdy_rfirst_i(b_rf),
    .budget_rfirst_rlast_i(b_rl), .clear_i(clear),
    .err_o(err), .fault_id_o(fault_id), .full_o(full), .irq_o(irq), .rst_req_o(rst_req)
  );

  always #5 clk = ~clk;

  // Reference model: each transaction remembers its arrival sequence number;
  // an R beat always belongs to the oldest outstanding transaction of its ID.
  bit            m_valid [NT];
  bit            m_first [NT];
  logic [IW-1:0] m_id    [NT];
  int            m_cnt   [NT];
  longint        m_seq   [NT];
  longint        m_next_seq;
  int            m_stall;
  logic [4:0]    m_err;
  logic [IW-1:0] m_fault;
  bit            m_rst_req;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < NT; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_eval();
    bit [4:0] ne;
    bit rf_hit, rl_hit, full_now;
    logic [IW-1:0] rf_id, rl_id, sel;
    int fr, m;
    if (rst) begin
      for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
      m_stall = 0; m_err = '0; m_fault = '0; m_rst_req = 1'b0;
      return;
    end
    ne = '0; rf_hit = 0; rl_hit = 0; rf_id = '0; rl_id = '0;
    if (ena) begin
      full_now = m_full();
      fr = -1;
      for (int i = 0; i < NT; i++) if (!m_valid[i] && fr < 0) fr = i;
      for (int i = 0; i < NT; i++) begin
        if (!m_valid[i]) continue;
        if (m_first[i] && b_rf != 0 && m_cnt[i] == int'(b_rf) && !rf_hit) begin
          rf_hit = 1; rf_id = m_id[i];
        end
        if (!m_first[i] && b_rl != 0 && m_cnt[i] == int'(b_rl) && !rl_hit) begin
          rl_hit = 1; rl_id = m_id[i];
        end
        if (m_cnt[i] < CMAX) m_cnt[i]++;
      end
      ne[1] = rf_hit; ne[2] = rl_hit;
      if (!ar_valid || ar_ready) m_stall = 0;
      else begin
        if (m_stall < CMAX) m_stall++;
        if (b_ar != 0 && m_stall == int'(b_ar)) ne[0] = 1;
      end
      if (r_valid && r_ready) begin
        m = -1;
        for (int i = 0; i < NT; i++)
          if (m_valid[i] && m_id[i] == r_id && (m < 0 || m_seq[i] < m_seq[m])) m = i;
        if (m < 0) ne[4] = 1;
        else if (r_last) m_valid[m] = 0;
        else if (m_first[m]) begin m_first[m] = 0; m_cnt[m] = 0; end
      end
      if (ar_valid && ar_ready) begin
        if (full_now) ne[3] = 1;
        else begin
          m_valid[fr] = 1; m_first[fr] = 1; m_id[fr] = ar_id; m_cnt[fr] = 0;
          m_seq[fr] = m_next_seq; m_next_seq++;
        end
      end
    end
    if (ne[0]) sel = ar_id;
    else if (ne[1]) sel = rf_id;
    else if (ne[2]) sel = rl_id;
    else if (ne[3]) sel = ar_id;
    else sel = r_id;
    if (clear) begin
      m_err = '0; m_fault = '0; m_rst_req = 0;
    end else begin
      if (m_err == 0 && ne != 0) m_fault = sel;
      m_err = m_err | ne;
      if (ne[2:0] != 0) m_rst_req = 1;
    end
  endfunction

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check_eq("err_o", 32'(err), 32'(m_err));
    check_eq("fault_id_o", 32'(fault_id), 32'(m_fault));
    check_eq("full_o", 32'(full), 32'(m_full()));
    check_eq("irq_o", 32'(irq), 32'(m_err != 0));
    check_eq("rst_req_o", 32'(rst_req), 32'(m_rst_req));
  endtask

  task automatic quiet();
    ar_valid = 0; ar_ready = 0; r_valid = 0; r_ready = 0; r_last = 0; clear = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; step(); rst = 0; ena = 1;
  endtask

  task automatic idle(input int n);
    quiet();
    repeat (n) step();
  endtask

  task automatic send_ar(input int id);
    quiet(); ar_valid = 1; ar_ready = 1; ar_id = IW'(id); step();
  endtask

  task automatic send_r(input int id, input bit last);
    quiet(); r_valid = 1; r_ready = 1; r_id = IW'(id); r_last = last; step();
  endtask

  function automatic logic [CW-1:0] rand_budget();
    if ($urandom_range(3) == 0) return '0;
    return CW'($urandom_range(15, 3));
  endfunction

  initial begin
    do_reset();
    check_eq("reset_err", 32'(err), 0);
    check_eq("reset_full", 32'(full), 0);
    check_eq("reset_rst_req", 32'(rst_req), 0);

    // Clean transaction inside budgets
    b_ar = 5; b_rf = 10; b_rl = 10;
    send_ar(3); idle(1); send_r(3, 0); idle(2); send_r(3, 1); idle(3);
    check_eq("clean_err", 32'(err), 0);
    check_eq("clean_full", 32'(full), 0);

    // First-beat timeout, then clear
    do_reset(); b_ar = 0; b_rf = 5; b_rl = 0;
    send_ar(2); idle(8);
    check_eq("rfirst_err", 32'(err), 32'h02);
    check_eq("rfirst_irq", 32'(irq), 1);
    check_eq("rfirst_rst_req", 32'(rst_req), 1);
    check_eq("rfirst_fault_id", 32'(fault_id), 2);
    quiet(); clear = 1; step(); clear = 0;
    check_eq("clear_err", 32'(err), 0);
    check_eq("clear_fault_id", 32'(fault_id), 0);
    check_eq("clear_rst_req", 32'(rst_req), 0);

    // Same-ID ordering and unexpected response
    do_reset(); b_ar = 0; b_rf = 0; b_rl = 0;
    send_ar(1); send_ar(1); send_r(1, 1);
    check_eq("order_first_free", 32'(err), 0);
    send_r(1, 1);
    check_eq("order_second_free", 32'(err), 0);
    send_r(1, 1);
    check_eq("unexp_err", 32'(err), 32'h10);
    check_eq("unexp_fault_id", 32'(fault_id), 1);

    // Overflow after filling the table
    do_reset();
    for (int i = 0; i < NT; i++) send_ar(i);
    check_eq("fill_full", 32'(full), 1);
    check_eq("fill_err", 32'(err), 0);
    send_ar(8);
    check_eq("overflow_err", 32'(err), 32'h08);
    check_eq("overflow_fault_id", 32'(fault_id), 8);

    // AR stall budget: 4 stalled cycles reach budget 4; budget 0 never fires
    do_reset(); b_ar = 4;
    quiet(); ar_valid = 1; ar_id = 4'd6;
    repeat (4) step();
    check_eq("ar_to_err", 32'(err), 32'h01);
    check_eq("ar_to_fault_id", 32'(fault_id), 6);
    do_reset(); b_ar = 0;
    quiet(); ar_valid = 1;
    repeat (10) step();
    check_eq("ar_to_disabled", 32'(err), 0);

    // Full table with same-cycle AR and R last: freed slot not reusable until next cycle
    do_reset(); b_ar = 0;
    for (int i = 0; i < NT; i++) send_ar(i);
    quiet(); ar_valid = 1; ar_ready = 1; ar_id = 4'd7;
    r_valid = 1; r_ready = 1; r_last = 1; r_id = 4'd3; step();
    check_eq("same_cycle_overflow", 32'(err), 32'h08);
    check_eq("same_cycle_fault_id", 32'(fault_id), 7);
    check_eq("same_cycle_freed", 32'(full), 0);
    send_ar(7);
    check_eq("reuse_full", 32'(full), 1);
    check_eq("reuse_err", 32'(err), 32'h08);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) begin
        b_ar = rand_budget(); b_rf = rand_budget(); b_rl = rand_budget();
      end
      rst      = (cyc % 1000 == 999);
      ena      = ($urandom_range(9) != 0);
      ar_valid = ($urandom_range(4) < 2);
      ar_ready = ($urandom_range(3) != 0);
      ar_id    = IW'($urandom_range(3));
      r_valid  = ($urandom_range(4) < 2);
      r_ready  = ($urandom_range(4) != 0);
      r_last   = $urandom_range(1);
      begin
        int k;
        k = $urandom_range(NT - 1);
        if ($urandom_range(3) != 0 && m_valid[k]) r_id = m_id[k];
        else r_id = IW'($urandom_range(3));
      end
      clear = ($urandom_range(19) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
